// File: rtl/rvv_backend_pkg.sv
// Shared vector-backend types: execution-unit encoding, Uop Queue payload and
// the reservation-station credit-width helper.
package rvv_backend_pkg;

  typedef enum logic [1:0] {
    EXE_ALU = 2'd0,
    EXE_MUL = 2'd1,
    EXE_LSU = 2'd2,
    EXE_ILL = 2'd3
  } EXE_UNIT_e;

  localparam int unsigned UOP_INSN_W = 32;
  localparam int unsigned VREG_IDX_W = 5;

  typedef struct packed {
    logic [UOP_INSN_W-1:0] insn;
    logic [VREG_IDX_W-1:0] vd;
    EXE_UNIT_e             uop_exe_unit;
    logic                  ordered;
  } UOP_QUEUE_t;

  // Width of a credit counter able to hold 0..depth inclusive.
  function automatic int unsigned credit_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rvv_backend_rs_credit.sv
// Reservation-station credit counter: consumes up to two credits per cycle,
// regains one per release, saturates at DEPTH and reloads on flush.
module rvv_backend_rs_credit
  import rvv_backend_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   push_cnt,
  input  logic                         rel,
  input  logic                         reload,
  output logic [credit_w(DEPTH)-1:0]   credit
);

  localparam int unsigned CW = credit_w(DEPTH);

  logic [CW:0] sum_c;

  // One extra bit so a release at full credit is visible before clamping.
  always_comb begin
    sum_c = (CW+1)'(credit) + (CW+1)'(rel) - (CW+1)'(push_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst || reload) begin
      credit <= CW'(DEPTH);
    end else if (sum_c > (CW+1)'(DEPTH)) begin
      credit <= CW'(DEPTH);
    end else begin
      credit <= sum_c[CW-1:0];
    end
  end

endmodule

// File: rtl/rvv_backend_dispatch_ctrl.sv
// Two-wide in-order dispatch from the Uop Queue into the ALU/MUL/LSU
// reservation stations, gated by RS credits, ROB room and ordering.
module rvv_backend_dispatch_ctrl
  import rvv_backend_pkg::*;
#(
  parameter int unsigned ALU_RS_DEPTH = 8,
  parameter int unsigned MUL_RS_DEPTH = 4,
  parameter int unsigned LSU_RS_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       uq_valid0,
  input  logic       uq_valid1,
  input  UOP_QUEUE_t uq_data0,
  input  UOP_QUEUE_t uq_data1,
  output logic       uq_pop0,
  output logic       uq_pop1,
  output logic       dsp_valid0,
  output logic       dsp_valid1,
  output UOP_QUEUE_t dsp_data0,
  output UOP_QUEUE_t dsp_data1,
  input  logic       alu_rel,
  input  logic       mul_rel,
  input  logic       lsu_rel,
  input  logic       rob_full,
  input  logic       rob_1left_to_full,
  input  logic       rob_empty,
  output logic       dsp_err
);

  localparam int unsigned ALU_CW = credit_w(ALU_RS_DEPTH);
  localparam int unsigned MUL_CW = credit_w(MUL_RS_DEPTH);
  localparam int unsigned LSU_CW = credit_w(LSU_RS_DEPTH);

  localparam logic [0:0] ST_RUN        = 1'b0;
  localparam logic [0:0] ST_WAIT_EMPTY = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [ALU_CW-1:0] alu_credit;
  logic [MUL_CW-1:0] mul_credit;
  logic [LSU_CW-1:0] lsu_credit;
  logic [1:0]        alu_push_c;
  logic [1:0]        mul_push_c;
  logic [1:0]        lsu_push_c;
  logic [3:0]        ge1_c;
  logic [3:0]        ge2_c;
  logic              quiet_c;
  logic              legal0_c;
  logic              legal1_c;
  logic              err_set_c;
  EXE_UNIT_e         unit0_c;
  EXE_UNIT_e         unit1_c;

  assign unit0_c  = uq_data0.uop_exe_unit;
  assign unit1_c  = uq_data1.uop_exe_unit;
  assign legal0_c = (unit0_c != EXE_ILL);
  assign legal1_c = (unit1_c != EXE_ILL);
  assign quiet_c  = rob_empty & ~dsp_valid0 & ~dsp_valid1;

  // Per-unit credit availability; the illegal encoding never has credit.
  assign ge1_c = {1'b0, 32'(lsu_credit) >= 32'd1, 32'(mul_credit) >= 32'd1,
                  32'(alu_credit) >= 32'd1};
  assign ge2_c = {1'b0, 32'(lsu_credit) >= 32'd2, 32'(mul_credit) >= 32'd2,
                  32'(alu_credit) >= 32'd2};

  assign err_set_c = ~flush & ((uq_valid0 & ~legal0_c) | (uq_valid1 & ~legal1_c));

  // Next-state and pop decode.
  always_comb begin
    state_nxt = state;
    uq_pop0   = 1'b0;
    uq_pop1   = 1'b0;
    case (state)
      ST_RUN: begin
        uq_pop0 = ~rst & ~flush & uq_valid0 & legal0_c & ge1_c[unit0_c] & ~rob_full
                & (~uq_data0.ordered | quiet_c);
        if (uq_valid0 & uq_data0.ordered & ~quiet_c) begin
          state_nxt = ST_WAIT_EMPTY;
        end
      end
      ST_WAIT_EMPTY: begin
        if (quiet_c) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
    uq_pop1 = uq_pop0 & uq_valid1 & ~uq_data0.ordered & ~uq_data1.ordered & legal1_c
            & ~rob_1left_to_full
            & ((unit1_c == unit0_c) ? ge2_c[unit1_c] : ge1_c[unit1_c]);
    if (flush) begin
      state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      dsp_valid0 <= 1'b0;
      dsp_valid1 <= 1'b0;
      dsp_data0  <= '0;
      dsp_data1  <= '0;
      dsp_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      dsp_valid0 <= uq_pop0;
      dsp_valid1 <= uq_pop1;
      dsp_data0  <= uq_data0;
      dsp_data1  <= uq_data1;
      dsp_err    <= dsp_err | err_set_c;
    end
  end

  assign alu_push_c = 2'(uq_pop0 && unit0_c == EXE_ALU) + 2'(uq_pop1 && unit1_c == EXE_ALU);
  assign mul_push_c = 2'(uq_pop0 && unit0_c == EXE_MUL) + 2'(uq_pop1 && unit1_c == EXE_MUL);
  assign lsu_push_c = 2'(uq_pop0 && unit0_c == EXE_LSU) + 2'(uq_pop1 && unit1_c == EXE_LSU);

  rvv_backend_rs_credit #(.DEPTH(ALU_RS_DEPTH)) u_alu_credit (
    .clk(clk), .rst(rst), .push_cnt(alu_push_c), .rel(alu_rel), .reload(flush),
    .credit(alu_credit)
  );

  rvv_backend_rs_credit #(.DEPTH(MUL_RS_DEPTH)) u_mul_credit (
    .clk(clk), .rst(rst), .push_cnt(mul_push_c), .rel(mul_rel), .reload(flush),
    .credit(mul_credit)
  );

  rvv_backend_rs_credit #(.DEPTH(LSU_RS_DEPTH)) u_lsu_credit (
    .clk(clk), .rst(rst), .push_cnt(lsu_push_c), .rel(lsu_rel), .reload(flush),
    .credit(lsu_credit)
  );

endmodule

// File: tb/tb_rvv_backend_dispatch_ctrl.sv
// Bench for rvv_backend_dispatch_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a credit/ordering model.
module tb_rvv_backend_dispatch_ctrl;
  import rvv_backend_pkg::*;

  logic       clk;
  logic       rst, flush, uq_valid0, uq_valid1;
  UOP_QUEUE_t uq_data0, uq_data1;
  logic       uq_pop0, uq_pop1, dsp_valid0, dsp_valid1;
  UOP_QUEUE_t dsp_data0, dsp_data1;
  logic       alu_rel, mul_rel, lsu_rel, rob_full, rob_1left_to_full, rob_empty, dsp_err;

  rvv_backend_dispatch_ctrl #(.ALU_RS_DEPTH(8), .MUL_RS_DEPTH(4), .LSU_RS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .uq_valid0(uq_valid0), .uq_valid1(uq_valid1), .uq_data0(uq_data0), .uq_data1(uq_data1),
    .uq_pop0(uq_pop0), .uq_pop1(uq_pop1),
    .dsp_valid0(dsp_valid0), .dsp_valid1(dsp_valid1), .dsp_data0(dsp_data0), .dsp_data1(dsp_data1),
    .alu_rel(alu_rel), .mul_rel(mul_rel), .lsu_rel(lsu_rel),
    .rob_full(rob_full), .rob_1left_to_full(rob_1left_to_full), .rob_empty(rob_empty),
    .dsp_err(dsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: credits per unit as plain integers, a wait flag for
  // ordered uops, and the uops expected on the dispatch outputs.
  int         depth[3];
  int         cred[3];
  bit         m_wait, m_v0, m_v1, m_err;
  UOP_QUEUE_t m_d0, m_d1;
  bit         exp_p0, exp_p1;
  int         n_vec, n_err;

  function automatic UOP_QUEUE_t mk_uop(input int unit, input bit ord);
    UOP_QUEUE_t u;
    u.insn         = $urandom;
    u.vd           = 5'($urandom);
    u.uop_exe_unit = EXE_UNIT_e'(2'(unit));
    u.ordered      = ord;
    return u;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) cred[k] = depth[k];
    m_wait = 0; m_v0 = 0; m_v1 = 0; m_err = 0; m_d0 = '0; m_d1 = '0;
  endtask

  task automatic predict();
    int u0, u1;
    bit q;
    u0 = int'(uq_data0.uop_exe_unit);
    u1 = int'(uq_data1.uop_exe_unit);
    q  = rob_empty && !m_v0 && !m_v1;
    exp_p0 = !rst && !m_wait && !flush && uq_valid0 && u0 != 3 && !rob_full
          && (!uq_data0.ordered || q);
    if (exp_p0 && cred[u0] < 1) exp_p0 = 0;
    exp_p1 = exp_p0 && uq_valid1 && !uq_data0.ordered && !uq_data1.ordered && u1 != 3
          && !rob_1left_to_full;
    if (exp_p1 && cred[u1] < ((u1 == u0) ? 2 : 1)) exp_p1 = 0;
  endtask

  task automatic advance();
    int u0, u1, push, rel;
    bit q;
    u0 = int'(uq_data0.uop_exe_unit);
    u1 = int'(uq_data1.uop_exe_unit);
    q  = rob_empty && !m_v0 && !m_v1;
    if (rst) begin
      model_reset();
    end else if (flush) begin
      for (int k = 0; k < 3; k++) cred[k] = depth[k];
      m_wait = 0; m_v0 = 0; m_v1 = 0; m_d0 = uq_data0; m_d1 = uq_data1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        push = int'(exp_p0 && u0 == k) + int'(exp_p1 && u1 == k);
        rel  = (k == 0) ? int'(alu_rel) : (k == 1) ? int'(mul_rel) : int'(lsu_rel);
        cred[k] = cred[k] - push + rel;
        if (cred[k] > depth[k]) cred[k] = depth[k];
      end
      if (m_wait) m_wait = !q;
      else        m_wait = uq_valid0 && uq_data0.ordered && !q;
      if ((uq_valid0 && u0 == 3) || (uq_valid1 && u1 == 3)) m_err = 1;
      m_v0 = exp_p0; m_v1 = exp_p1; m_d0 = uq_data0; m_d1 = uq_data1;
    end
  endtask

  task automatic settle();
    #1;
    predict();
  endtask

  task automatic edge_adv();
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic quiet_inputs();
    rst = 0; flush = 0; uq_valid0 = 0; uq_valid1 = 0;
    uq_data0 = mk_uop(0, 0); uq_data1 = mk_uop(0, 0);
    alu_rel = 0; mul_rel = 0; lsu_rel = 0;
    rob_full = 0; rob_1left_to_full = 0; rob_empty = 1;
  endtask

  task automatic set_uops(input int u0, input bit o0, input int u1, input bit o1, input bit v1);
    uq_valid0 = 1; uq_data0 = mk_uop(u0, o0);
    uq_valid1 = v1; uq_data1 = mk_uop(u1, o1);
  endtask

  task automatic restore();
    quiet_inputs();
    alu_rel = 1; mul_rel = 1; lsu_rel = 1;
    repeat (10) begin settle(); edge_adv(); end
    quiet_inputs();
    settle(); edge_adv();
  endtask

  task automatic test_reset();
    UOP_QUEUE_t s0;
    quiet_inputs(); rst = 1; set_uops(0, 0, 0, 0, 1);
    repeat (2) begin
      settle();
      n_vec++; if (uq_pop0 !== 1'b0) begin n_err++; $display("FAIL reset_pop0: got %b want 0", uq_pop0); end
      n_vec++; if (uq_pop1 !== 1'b0) begin n_err++; $display("FAIL reset_pop1: got %b want 0", uq_pop1); end
      edge_adv();
    end
    n_vec++; if (dsp_valid0 !== 1'b0) begin n_err++; $display("FAIL reset_valid0: got %b want 0", dsp_valid0); end
    n_vec++; if (dsp_valid1 !== 1'b0) begin n_err++; $display("FAIL reset_valid1: got %b want 0", dsp_valid1); end
    n_vec++; if (dsp_data0 !== '0) begin n_err++; $display("FAIL reset_data0: got %h want 0", dsp_data0); end
    n_vec++; if (dsp_data1 !== '0) begin n_err++; $display("FAIL reset_data1: got %h want 0", dsp_data1); end
    n_vec++; if (dsp_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", dsp_err); end
    // Reset landing while uops sit in the dispatch registers drops them.
    rst = 0; set_uops(0, 0, 0, 0, 1); s0 = uq_data0;
    settle(); edge_adv();
    n_vec++; if (dsp_data0 !== s0) begin n_err++; $display("FAIL pre_reset_data0: got %h want %h", dsp_data0, s0); end
    rst = 1; settle(); edge_adv();
    n_vec++; if (dsp_valid0 !== 1'b0 || dsp_valid1 !== 1'b0)
      begin n_err++; $display("FAIL midreset_valid: got %b%b want 00", dsp_valid0, dsp_valid1); end
    quiet_inputs(); settle(); edge_adv();
  endtask

  task automatic test_alu_credit();
    UOP_QUEUE_t s0, s1;
    quiet_inputs(); set_uops(0, 0, 0, 0, 1); s0 = uq_data0; s1 = uq_data1;
    settle();
    n_vec++; if ({uq_pop0, uq_pop1} !== 2'b11) begin n_err++; $display("FAIL dual_alu_pops: got %b%b want 11", uq_pop0, uq_pop1); end
    edge_adv();
    n_vec++; if ({dsp_valid0, dsp_valid1} !== 2'b11) begin n_err++; $display("FAIL dual_alu_valid: got %b%b want 11", dsp_valid0, dsp_valid1); end
    n_vec++; if (dsp_data0 !== s0 || dsp_data1 !== s1) begin n_err++; $display("FAIL dual_alu_data: got %h/%h want %h/%h", dsp_data0, dsp_data1, s0, s1); end
    // Six credits left: exactly three more dual dispatches fit.
    for (int i = 0; i < 4; i++) begin
      set_uops(0, 0, 0, 0, 1); settle();
      n_vec++; if ({uq_pop0, uq_pop1} !== ((i < 3) ? 2'b11 : 2'b00))
        begin n_err++; $display("FAIL alu_drain_%0d: got %b%b", i, uq_pop0, uq_pop1); end
      edge_adv();
    end
    quiet_inputs(); alu_rel = 1; settle(); edge_adv();
    alu_rel = 0; set_uops(0, 0, 0, 0, 1); settle();
    n_vec++; if ({uq_pop0, uq_pop1} !== 2'b10) begin n_err++; $display("FAIL alu_one_credit: got %b%b want 10", uq_pop0, uq_pop1); end
    edge_adv();
    // Surplus releases must clamp at the RS depth.
    quiet_inputs(); alu_rel = 1;
    repeat (12) begin settle(); edge_adv(); end
    alu_rel = 0;
    for (int i = 0; i < 5; i++) begin
      set_uops(0, 0, 0, 0, 1); settle();
      n_vec++; if ({uq_pop0, uq_pop1} !== ((i < 4) ? 2'b11 : 2'b00))
        begin n_err++; $display("FAIL alu_saturate_%0d: got %b%b", i, uq_pop0, uq_pop1); end
      edge_adv();
    end
    restore();
  endtask

  task automatic test_mul_credit();
    logic [1:0] want[5];
    want = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b00};
    for (int i = 0; i < 5; i++) begin
      quiet_inputs();
      set_uops(1, 0, (i == 0) ? 0 : 1, 0, 1);
      mul_rel = (i == 2);
      settle();
      n_vec++; if ({uq_pop0, uq_pop1} !== want[i])
        begin n_err++; $display("FAIL mul_credit_%0d: got %b%b want %b", i, uq_pop0, uq_pop1, want[i]); end
      edge_adv();
    end
    restore();
  endtask

  task automatic test_ordered();
    logic [1:0] want[4];
    want = '{2'b00, 2'b00, 2'b00, 2'b10};
    for (int i = 0; i < 4; i++) begin
      quiet_inputs(); set_uops(0, 1, 0, 0, 1);
      rob_empty = (i >= 2);
      settle();
      n_vec++; if ({uq_pop0, uq_pop1} !== want[i])
        begin n_err++; $display("FAIL ordered_%0d: got %b%b want %b", i, uq_pop0, uq_pop1, want[i]); end
      edge_adv();
    end
    n_vec++; if ({dsp_valid0, dsp_valid1} !== 2'b10) begin n_err++; $display("FAIL ordered_alone: got %b%b want 10", dsp_valid0, dsp_valid1); end
    quiet_inputs(); set_uops(0, 0, 0, 1, 1); settle();
    n_vec++; if ({uq_pop0, uq_pop1} !== 2'b10) begin n_err++; $display("FAIL ordered_slot1: got %b%b want 10", uq_pop0, uq_pop1); end
    edge_adv();
    quiet_inputs(); settle(); edge_adv();
  endtask

  task automatic test_rob_limits();
    quiet_inputs(); set_uops(0, 0, 0, 0, 1); rob_1left_to_full = 1; settle();
    n_vec++; if ({uq_pop0, uq_pop1} !== 2'b10) begin n_err++; $display("FAIL rob_1left: got %b%b want 10", uq_pop0, uq_pop1); end
    edge_adv();
    rob_full = 1; set_uops(0, 0, 0, 0, 1); settle();
    n_vec++; if ({uq_pop0, uq_pop1} !== 2'b00) begin n_err++; $display("FAIL rob_full: got %b%b want 00", uq_pop0, uq_pop1); end
    edge_adv();
    restore();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      quiet_inputs(); set_uops(2, 0, 2, 0, 1); settle(); edge_adv();
    end
    n_vec++; if (dsp_valid0 !== 1'b1) begin n_err++; $display("FAIL preflush_valid0: got %b want 1", dsp_valid0); end
    set_uops(2, 0, 2, 0, 1); flush = 1; lsu_rel = 1; settle();
    n_vec++; if ({uq_pop0, uq_pop1} !== 2'b00) begin n_err++; $display("FAIL flush_pops: got %b%b want 00", uq_pop0, uq_pop1); end
    edge_adv();
    n_vec++; if ({dsp_valid0, dsp_valid1} !== 2'b00) begin n_err++; $display("FAIL flush_valid: got %b%b want 00", dsp_valid0, dsp_valid1); end
    // LSU credits reloaded to four.
    for (int i = 0; i < 3; i++) begin
      quiet_inputs(); set_uops(2, 0, 2, 0, 1); settle();
      n_vec++; if ({uq_pop0, uq_pop1} !== ((i < 2) ? 2'b11 : 2'b00))
        begin n_err++; $display("FAIL flush_reload_%0d: got %b%b", i, uq_pop0, uq_pop1); end
      edge_adv();
    end
    restore();
    // Flush while waiting on an ordered uop returns to dispatching.
    quiet_inputs(); set_uops(0, 1, 0, 0, 0); rob_empty = 0; settle(); edge_adv();
    flush = 1; settle(); edge_adv();
    flush = 0; rob_empty = 1; set_uops(0, 1, 0, 0, 0); settle();
    n_vec++; if ({uq_pop0, uq_pop1} !== 2'b10) begin n_err++; $display("FAIL flush_wait_to_run: got %b%b want 10", uq_pop0, uq_pop1); end
    edge_adv();
    restore();
  endtask

  task automatic test_illegal();
    quiet_inputs(); set_uops(3, 0, 0, 0, 1); settle();
    n_vec++; if ({uq_pop0, uq_pop1} !== 2'b00) begin n_err++; $display("FAIL illegal_pops: got %b%b want 00", uq_pop0, uq_pop1); end
    edge_adv();
    quiet_inputs();
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (dsp_err !== 1'b1) begin n_err++; $display("FAIL illegal_err_hold_%0d: got %b want 1", i, dsp_err); end
      settle(); edge_adv();
    end
    rst = 1; settle(); edge_adv(); rst = 0;
    n_vec++; if (dsp_err !== 1'b0) begin n_err++; $display("FAIL illegal_err_rst: got %b want 0", dsp_err); end
    set_uops(0, 0, 3, 0, 1); settle();
    n_vec++; if ({uq_pop0, uq_pop1} !== 2'b10) begin n_err++; $display("FAIL illegal_slot1: got %b%b want 10", uq_pop0, uq_pop1); end
    edge_adv();
    n_vec++; if (dsp_err !== 1'b1) begin n_err++; $display("FAIL illegal_slot1_err: got %b want 1", dsp_err); end
    quiet_inputs(); rst = 1; settle(); edge_adv();
    quiet_inputs(); settle(); edge_adv();
  endtask

  task automatic test_random();
    int u;
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(99) == 0);
      flush = ($urandom_range(19) == 0);
      uq_valid0 = ($urandom_range(3) != 0);
      uq_valid1 = ($urandom_range(2) != 0);
      u = ($urandom_range(49) == 0) ? 3 : int'($urandom_range(2));
      uq_data0 = mk_uop(u, $urandom_range(7) == 0);
      u = ($urandom_range(49) == 0) ? 3 : int'($urandom_range(2));
      uq_data1 = mk_uop(u, $urandom_range(7) == 0);
      alu_rel = ($urandom_range(2) == 0);
      mul_rel = ($urandom_range(2) == 0);
      lsu_rel = ($urandom_range(2) == 0);
      rob_full          = ($urandom_range(9) == 0);
      rob_1left_to_full = ($urandom_range(4) == 0);
      rob_empty         = 1'($urandom_range(1));
      settle();
      n_vec++; if (uq_pop0 !== exp_p0) begin n_err++; $display("FAIL rand_pop0 @%0d: got %b want %b", i, uq_pop0, exp_p0); end
      n_vec++; if (uq_pop1 !== exp_p1) begin n_err++; $display("FAIL rand_pop1 @%0d: got %b want %b", i, uq_pop1, exp_p1); end
      edge_adv();
      n_vec++; if (dsp_valid0 !== m_v0) begin n_err++; $display("FAIL rand_valid0 @%0d: got %b want %b", i, dsp_valid0, m_v0); end
      n_vec++; if (dsp_valid1 !== m_v1) begin n_err++; $display("FAIL rand_valid1 @%0d: got %b want %b", i, dsp_valid1, m_v1); end
      n_vec++; if (dsp_err !== m_err) begin n_err++; $display("FAIL rand_err @%0d: got %b want %b", i, dsp_err, m_err); end
      if (m_v0) begin
        n_vec++; if (dsp_data0 !== m_d0) begin n_err++; $display("FAIL rand_data0 @%0d: got %h want %h", i, dsp_data0, m_d0); end
      end
      if (m_v1) begin
        n_vec++; if (dsp_data1 !== m_d1) begin n_err++; $display("FAIL rand_data1 @%0d: got %h want %h", i, dsp_data1, m_d1); end
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    depth = '{8, 4, 4};
    model_reset();
    exp_p0 = 0; exp_p1 = 0;
    quiet_inputs(); rst = 1;
    @(negedge clk);
    test_reset();
    test_alu_credit();
    test_mul_credit();
    test_ordered();
    test_rob_limits();
    test_flush();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
